// File: rtl/padovan_result_uart_pkg.sv
// Shared definitions for the Padovan result UART: TX state codes, frame length
// and the clocks-per-bit calculation.
package padovan_result_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  localparam int UART_FRAME_BITS = 10;

  // Clocks per bit, truncated toward zero.
  function automatic int calcDiv(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// First-word-fall-through synchronous FIFO. The head entry is always on dout
// while the FIFO is non-empty. A push into a full FIFO is accepted only when a
// pop happens in the same cycle. Flags are registered.
module fifo_sync #(
  parameter int DATAWIDTH  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 empty,
  output logic                 full
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr, rdPtr;
  logic [AW:0]          count, countNext;
  logic                 doPush, doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    countNext = count;
    case ({doPush, doPop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Pointers, occupancy and registered flags; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      empty <= (countNext == '0);
      full  <= (countNext == DEPTH_C);
    end
  end

  // Storage array, no reset needed: contents are only read when non-empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/padovan_result_uart.sv
// Snoops bus C writes to the result register, queues each new value and
// ships it out as an 8N1 UART frame. Never back-pressures the datapath:
// captures that find the queue full are counted and discarded.
module padovan_result_uart
  import padovan_result_uart_pkg::*;
#(
  parameter int DATAWIDTH     = 8,
  parameter int SELECTIONDECO = 3,
  parameter int CAPTURE_REG   = 0,
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD          = 115200,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SELECTIONDECO-1:0] sSelDecoC,
  input  logic [DATAWIDTH-1:0]     sDataInBusC,
  input  logic                     sEnable,
  output logic                     sTxd,
  output logic                     sBusy,
  output logic                     sFifoEmpty,
  output logic                     sFifoFull,
  output logic [7:0]               sDropCount
);

  localparam int DIV = calcDiv(CLK_FREQ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [BW-1:0]            DIV_M1   = BW'(DIV - 1);
  localparam logic [CW-1:0]            LAST_BIT = CW'(DATAWIDTH - 1);
  localparam logic [SELECTIONDECO-1:0] CAP      = SELECTIONDECO'(CAPTURE_REG);

  logic [SELECTIONDECO-1:0] selQ;
  logic                     capture, fifoPop, drop;
  logic [DATAWIDTH-1:0]     fifoDout, shifter;
  logic [BW-1:0]            baudCnt;
  logic [CW-1:0]            bitCnt;
  txState_t                 state;

  // A capture is the first cycle the select lands on the result register.
  assign capture = sEnable && (sSelDecoC == CAP) && (selQ != CAP);
  assign fifoPop = (state == IDLE) && !sFifoEmpty;
  // A same-cycle pop frees a slot, so only a full FIFO with no pop drops.
  assign drop    = capture && sFifoFull && !fifoPop;

  fifo_sync #(
    .DATAWIDTH (DATAWIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk  (clk),
    .rst  (rst),
    .push (capture),
    .pop  (fifoPop),
    .din  (sDataInBusC),
    .dout (fifoDout),
    .empty(sFifoEmpty),
    .full (sFifoFull)
  );

  // Registered select; reset value differs from the result register so a
  // select already sitting on it right after reset still counts as new.
  always_ff @(posedge clk) begin
    if (rst) selQ <= ~CAP;
    else     selQ <= sSelDecoC;
  end

  // Saturating count of captures lost to a full queue.
  always_ff @(posedge clk) begin
    if (rst)                             sDropCount <= '0;
    else if (drop && sDropCount != 8'hFF) sDropCount <= sDropCount + 1'b1;
  end

  // Frame sequencer: start bit, LSB-first data, stop bit, each DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sTxd    <= 1'b1;
      sBusy   <= 1'b0;
      shifter <= '0;
      baudCnt <= '0;
      bitCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!sFifoEmpty) begin
            shifter <= fifoDout;
            baudCnt <= DIV_M1;
            sTxd    <= 1'b0;
            sBusy   <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (baudCnt == '0) begin
            sTxd    <= shifter[0];
            shifter <= shifter >> 1;
            baudCnt <= DIV_M1;
            bitCnt  <= '0;
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        DATA: begin
          if (baudCnt == '0) begin
            baudCnt <= DIV_M1;
            if (bitCnt == LAST_BIT) begin
              sTxd  <= 1'b1;
              state <= STOP;
            end else begin
              sTxd    <= shifter[0];
              shifter <= shifter >> 1;
              bitCnt  <= bitCnt + 1'b1;
            end
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        STOP: begin
          if (baudCnt == '0) begin
            sBusy <= 1'b0;
            state <= IDLE;
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_padovan_result_uart.sv
// Bench for padovan_result_uart at DIV=16: a queue-based reference of the
// capture/queue/line behaviour checked every cycle, an independent line
// receiver, and directed scenarios with literal expectations.
module tb_padovan_result_uart;

  localparam int DIV   = 16;
  localparam int FRAME = 160;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sSelDecoC = 3'd3;
  logic [7:0] sDataInBusC = 8'h00;
  logic       sEnable = 1'b1;
  logic       sTxd, sBusy, sFifoEmpty, sFifoFull;
  logic [7:0] sDropCount;

  int checks = 0;
  int failures = 0;

  padovan_result_uart #(
    .DATAWIDTH(8), .SELECTIONDECO(3), .CAPTURE_REG(0),
    .CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .sSelDecoC(sSelDecoC), .sDataInBusC(sDataInBusC),
    .sEnable(sEnable), .sTxd(sTxd), .sBusy(sBusy), .sFifoEmpty(sFifoEmpty),
    .sFifoFull(sFifoFull), .sDropCount(sDropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  logic [2:0] mSelQ;
  logic [7:0] mByte;
  int         mDrop, mT;
  bit         mActive, mTxd, mValid = 0, mCap, mPop;
  int         mSz;

  function automatic bit frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Advance the reference by one clock from the inputs alone.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); mSelQ = 3'b111; mDrop = 0; mActive = 0; mT = 0; mTxd = 1; mValid = 1;
    end else begin
      mCap = sEnable && (sSelDecoC == 3'd0) && (mSelQ != 3'd0);
      mSz  = mq.size();
      mPop = 0;
      if (mActive) begin
        mT++;
        if (mT == FRAME) begin mActive = 0; mTxd = 1; end
        else mTxd = frameBit(mByte, mT / DIV);
      end else if (mSz > 0) begin
        mByte = mq.pop_front(); mPop = 1; mActive = 1; mT = 0; mTxd = 0;
      end
      if (mCap) begin
        if (mSz < DEPTH || mPop) mq.push_back(sDataInBusC);
        else if (mDrop < 255) mDrop++;
      end
      mSelQ = sSelDecoC;
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (mValid) begin
      chk("cmp_txd",   sTxd,       mTxd);
      chk("cmp_busy",  sBusy,      mActive);
      chk("cmp_empty", sFifoEmpty, mq.size() == 0);
      chk("cmp_full",  sFifoFull,  mq.size() == DEPTH);
      chk("cmp_drop",  sDropCount, mDrop);
    end
  end

  // ---------------- line receiver ----------------
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];
  logic [7:0] rxByte;
  logic       rxPrev = 1'b1;
  bit         rxActive = 0;
  int         rxCnt = 0;

  always @(negedge clk) begin
    if (rxActive) begin
      rxCnt++;
      if (rxCnt == 9 * DIV + DIV / 2) begin
        chk("rx_stop_bit", sTxd, 1);
        rxQ.push_back(rxByte);
        rxActive = 0;
      end else if (rxCnt % DIV == DIV / 2 && rxCnt > DIV) begin
        rxByte[rxCnt / DIV - 1] = sTxd;
      end
    end else if (mValid && rxPrev === 1'b1 && sTxd === 1'b0) begin
      rxActive = 1; rxCnt = 0;
    end
    rxPrev = sTxd;
  end

  // ---------------- stimulus helpers ----------------
  task automatic writeReg(input logic [2:0] s, input logic [7:0] d);
    @(negedge clk); sSelDecoC = s; sDataInBusC = d;
  endtask

  task automatic captureByte(input logic [7:0] d);
    writeReg(3'd0, d); writeReg(3'd3, 8'h00);
  endtask

  task automatic resetDut();
    @(negedge clk); rst = 1'b1; sSelDecoC = 3'd3; sEnable = 1'b1;
    @(negedge clk); rst = 1'b0; rxActive = 0; rxQ.delete();
  endtask

  task automatic waitRx(input int n, input int budget);
    int c = 0;
    while (rxQ.size() < n && c < budget) begin @(negedge clk); c++; end
    chk("rx_wait", rxQ.size() >= n, 1);
  endtask

  task automatic checkRx(input string name);
    chk({name, "_count"}, rxQ.size(), expQ.size());
    foreach (expQ[i]) chk(name, (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hFFFF_FFFF, expQ[i]);
  endtask

  logic [9:0] bits25 = 10'b1001001010;  // stop, 0x25 MSB..LSB, start
  logic [7:0] pad [10] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd9};
  int busyCnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk); rst = 1'b0;
    chk("rst_txd", sTxd, 1); chk("rst_busy", sBusy, 0); chk("rst_empty", sFifoEmpty, 1);
    chk("rst_full", sFifoFull, 0); chk("rst_drop", sDropCount, 0);

    // 1: single 0x25 frame, literal line timing
    resetDut();
    @(negedge clk); sSelDecoC = 3'd0; sDataInBusC = 8'h25;
    busyCnt = 0;
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      if (k == 1) sSelDecoC = 3'd3;
      if (sBusy) busyCnt++;
      for (int b = 0; b < 10; b++)
        if (k == 2 + 16 * b || k == 17 + 16 * b) chk("t1_txd_bit", sTxd, bits25[b]);
    end
    chk("t1_busy_cycles", busyCnt, 160);
    expQ.delete(); expQ.push_back(8'h25); checkRx("t1_rx");

    // 2: select held three cycles -> one frame carrying the first value
    resetDut();
    writeReg(3'd0, 8'h05); writeReg(3'd0, 8'h07); writeReg(3'd0, 8'h09); writeReg(3'd3, 8'h00);
    waitRx(1, 300);
    repeat (200) @(negedge clk);
    expQ.delete(); expQ.push_back(8'h05); checkRx("t2_rx");

    // 3: ten back-to-back captures, ninth fills the queue, tenth dropped
    resetDut();
    for (int i = 0; i < 10; i++) captureByte(8'h30 + 8'(i));
    chk("t3_full", sFifoFull, 1); chk("t3_drop", sDropCount, 1);
    waitRx(9, 9 * 161 + 200);
    expQ.delete(); for (int i = 0; i < 9; i++) expQ.push_back(8'h30 + 8'(i));
    checkRx("t3_rx");

    // 4: drop counter saturates
    resetDut();
    for (int i = 0; i < 310; i++) captureByte(8'(i));
    chk("t4_drop_sat", sDropCount, 255); chk("t4_full", sFifoFull, 1);

    // 5: reset mid-DATA with entries queued
    resetDut();
    for (int i = 0; i < 4; i++) captureByte(8'h11 + 8'(i));
    repeat (40) @(negedge clk);
    chk("t5_pre_busy", sBusy, 1); chk("t5_pre_empty", sFifoEmpty, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; rxActive = 0; rxQ.delete();
    chk("t5_txd", sTxd, 1); chk("t5_busy", sBusy, 0); chk("t5_empty", sFifoEmpty, 1);
    chk("t5_drop", sDropCount, 0);
    repeat (400) @(negedge clk);
    chk("t5_no_frames", rxQ.size(), 0);

    // 6: Padovan writes to R0 interleaved with other registers
    resetDut();
    for (int i = 0; i < 10; i++) begin
      writeReg(3'd1, 8'h11); writeReg(3'd2, 8'h22); writeReg(3'd0, pad[i]); writeReg(3'd3, pad[i]);
      repeat (36) @(negedge clk);
    end
    waitRx(10, 10 * 161 + 200);
    expQ.delete(); foreach (pad[i]) expQ.push_back(pad[i]);
    checkRx("t6_rx");

    // 6b: same writes with capture disabled
    resetDut();
    sEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      writeReg(3'd1, 8'h11); writeReg(3'd0, pad[i]); writeReg(3'd3, 8'h00);
    end
    repeat (300) @(negedge clk);
    chk("t6b_no_frames", rxQ.size(), 0); chk("t6b_empty", sFifoEmpty, 1);
    sEnable = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
